// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration sequencer: master register map,
// STATUS/CONFIG bit positions, error codes and sequencer states.
package i2c_pkg;

    localparam logic [7:0] REG_ADDR       = 8'h00;
    localparam logic [7:0] REG_CLK_DIV    = 8'h01;
    localparam logic [7:0] REG_CONFIG     = 8'h02;
    localparam logic [7:0] REG_STATUS     = 8'h03;
    localparam logic [7:0] REG_DATA_CACHE = 8'h10;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_NACK_BIT = 1;

    // CONFIG layout: enables in the low nibble, read direction flag, byte count in [15:8]
    localparam int CFG_START_EN_BIT  = 0;
    localparam int CFG_STOP_EN_BIT   = 1;
    localparam int CFG_INIT_BIT      = 2;
    localparam int CFG_READ_BIT      = 3;
    localparam int CFG_NUM_BYTES_LSB = 8;
    localparam int CFG_NUM_BYTES_W   = 8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_t;

    typedef enum logic [3:0] {
        IDLE,
        CLKDIV,
        FETCH,
        WR_ADDR,
        WR_D0,
        WR_D1,
        WR_CFG,
        GAP,
        POLL,
        CHECK,
        NEXT,
        FAIL
    } seq_state_t;

    function automatic logic [31:0] cfg_word(input logic [7:0] num_bytes, input logic read);
        logic [31:0] w;
        w                   = '0;
        w[CFG_START_EN_BIT] = 1'b1;
        w[CFG_STOP_EN_BIT]  = 1'b1;
        w[CFG_INIT_BIT]     = 1'b1;
        w[CFG_READ_BIT]     = read;
        w[CFG_NUM_BYTES_LSB +: CFG_NUM_BYTES_W] = num_bytes;
        return w;
    endfunction

endpackage

// File: rtl/lb_xact.sv
// Single-outstanding local-bus access engine: turns a one-cycle request into one
// strobe, holds address/data until the matching valid, then pulses ack.
module lb_xact #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              lb_wr_en,
    output logic              lb_rd_en,
    output logic [ADDR_W-1:0] lb_addr,
    output logic [DATA_W-1:0] lb_wr_data,
    input  logic              lb_wr_valid,
    input  logic              lb_rd_valid,
    input  logic [DATA_W-1:0] lb_rd_data
);

    logic pending;
    logic pending_wr;
    logic resp;

    assign resp = pending_wr ? lb_wr_valid : lb_rd_valid;

    // Requests arriving while an access is outstanding are dropped; the sequencer never does that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            pending_wr <= 1'b0;
            ack        <= 1'b0;
            rdata      <= '0;
            lb_wr_en   <= 1'b0;
            lb_rd_en   <= 1'b0;
            lb_addr    <= '0;
            lb_wr_data <= '0;
        end else begin
            lb_wr_en <= 1'b0;
            lb_rd_en <= 1'b0;
            ack      <= 1'b0;
            if (!pending) begin
                if (req) begin
                    pending    <= 1'b1;
                    pending_wr <= wr;
                    lb_addr    <= addr;
                    lb_wr_en   <= wr;
                    lb_rd_en   <= !wr;
                    if (wr) begin
                        lb_wr_data <= wdata;
                    end
                end
            end else if (resp) begin
                pending <= 1'b0;
                ack     <= 1'b1;
                if (!pending_wr) begin
                    rdata <= lb_rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks a configuration ROM and programs each entry into an I2C master over the
// local bus: device address, two data bytes, CONFIG kick, then STATUS polling.
module i2c_cfg_seq
    import i2c_pkg::*;
#(
    parameter int          LB_DATA_W   = 32,
    parameter int          LB_ADDR_W   = 8,
    parameter int          TBL_DEPTH   = 16,
    parameter int          TBL_IDX_W   = 4,
    parameter logic [7:0]  CLK_DIV_VAL = 8'd50,
    parameter int          POLL_GAP    = 8,
    parameter logic [15:0] POLL_MAX    = 16'hFFFF,
    parameter int          MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [TBL_IDX_W-1:0] err_idx,
    output logic [1:0]           err_code,
    output logic [TBL_IDX_W-1:0] tbl_addr,
    input  logic [23:0]          tbl_data,
    output logic                 lb_wr_en,
    output logic                 lb_rd_en,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [LB_DATA_W-1:0] lb_wr_data,
    input  logic                 lb_wr_valid,
    input  logic                 lb_rd_valid,
    input  logic [LB_DATA_W-1:0] lb_rd_data
);

    seq_state_t           state;
    logic [TBL_IDX_W-1:0] idx;
    logic [7:0]           retry;
    logic [7:0]           gap_cnt;
    logic [15:0]          poll_cnt;
    logic [1:0]           fetch_cnt;
    logic [6:0]           ent_dev;
    logic [7:0]           ent_b0;
    logic [7:0]           ent_b1;
    logic                 nack_seen;
    err_code_t            fail_code;

    logic                 req;
    logic                 req_wr;
    logic [LB_ADDR_W-1:0] req_addr;
    logic [LB_DATA_W-1:0] req_data;
    logic                 in_flight;
    logic                 ack;
    logic [LB_DATA_W-1:0] rdata;
    logic                 xfer_done;

    logic                 op_valid;
    logic                 op_wr;
    logic [7:0]           op_addr;
    logic [31:0]          op_data;

    logic                 unused_bits;
    assign unused_bits = ^{rdata, tbl_data[16]};

    assign xfer_done = in_flight && ack;

    // Which bus access (if any) the current state owns.
    always_comb begin
        op_valid = 1'b1;
        op_wr    = 1'b1;
        op_addr  = REG_ADDR;
        op_data  = '0;
        case (state)
            CLKDIV: begin
                op_addr = REG_CLK_DIV;
                op_data = 32'(CLK_DIV_VAL);
            end
            WR_ADDR: op_data = {24'h0, ent_dev, 1'b0};
            WR_D0: begin
                op_addr = REG_DATA_CACHE;
                op_data = {24'h0, ent_b0};
            end
            WR_D1: begin
                op_addr = REG_DATA_CACHE + 8'd1;
                op_data = {24'h0, ent_b1};
            end
            WR_CFG: begin
                op_addr = REG_CONFIG;
                op_data = cfg_word(8'd2, 1'b0);
            end
            POLL: begin
                op_wr   = 1'b0;
                op_addr = REG_STATUS;
            end
            default: op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            retry     <= '0;
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            fetch_cnt <= '0;
            ent_dev   <= '0;
            ent_b0    <= '0;
            ent_b1    <= '0;
            nack_seen <= 1'b0;
            fail_code <= ERR_NONE;
            req       <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            in_flight <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
            err_code  <= '0;
            tbl_addr  <= '0;
        end else begin
            req  <= 1'b0;
            done <= 1'b0;

            // Each bus state issues exactly one request on entry and then waits for its ack.
            if (op_valid && !in_flight) begin
                req       <= 1'b1;
                req_wr    <= op_wr;
                req_addr  <= LB_ADDR_W'(op_addr);
                req_data  <= LB_DATA_W'(op_data);
                in_flight <= 1'b1;
            end else if (xfer_done) begin
                in_flight <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        err_idx  <= '0;
                        err_code <= '0;
                        idx      <= '0;
                        retry    <= '0;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CLKDIV;
                    end
                end
                CLKDIV: begin
                    if (xfer_done) begin
                        fetch_cnt <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // Address is registered, ROM adds one more cycle before data is usable.
                    if (fetch_cnt == 2'd0) begin
                        tbl_addr  <= idx;
                        fetch_cnt <= 2'd1;
                    end else if (fetch_cnt == 2'd1) begin
                        fetch_cnt <= 2'd2;
                    end else begin
                        ent_dev <= tbl_data[23:17];
                        ent_b0  <= tbl_data[15:8];
                        ent_b1  <= tbl_data[7:0];
                        state   <= WR_ADDR;
                    end
                end
                WR_ADDR: if (xfer_done) state <= WR_D0;
                WR_D0:   if (xfer_done) state <= WR_D1;
                WR_D1:   if (xfer_done) state <= WR_CFG;
                WR_CFG: begin
                    if (xfer_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(POLL_GAP - 1)) begin
                        state <= POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                POLL: begin
                    if (xfer_done) begin
                        poll_cnt <= poll_cnt + 16'd1;
                        if (rdata[STATUS_BUSY_BIT]) begin
                            if (poll_cnt + 16'd1 == POLL_MAX) begin
                                fail_code <= ERR_TIMEOUT;
                                state     <= FAIL;
                            end else begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end
                        end else begin
                            nack_seen <= rdata[STATUS_NACK_BIT];
                            state     <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (!nack_seen) begin
                        state <= NEXT;
                    end else if (retry < 8'(MAX_RETRY)) begin
                        retry <= retry + 8'd1;
                        state <= WR_ADDR;
                    end else begin
                        fail_code <= ERR_NACK;
                        state     <= FAIL;
                    end
                end
                NEXT: begin
                    if (idx == TBL_IDX_W'(TBL_DEPTH - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx       <= idx + 1'b1;
                        retry     <= '0;
                        poll_cnt  <= '0;
                        fetch_cnt <= '0;
                        state     <= FETCH;
                    end
                end
                FAIL: begin
                    err      <= 1'b1;
                    err_idx  <= idx;
                    err_code <= fail_code;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    lb_xact #(
        .ADDR_W(LB_ADDR_W),
        .DATA_W(LB_DATA_W)
    ) u_xact (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wr         (req_wr),
        .addr       (req_addr),
        .wdata      (req_data),
        .ack        (ack),
        .rdata      (rdata),
        .lb_wr_en   (lb_wr_en),
        .lb_rd_en   (lb_rd_en),
        .lb_addr    (lb_addr),
        .lb_wr_data (lb_wr_data),
        .lb_wr_valid(lb_wr_valid),
        .lb_rd_valid(lb_rd_valid),
        .lb_rd_data (lb_rd_data)
    );

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: an I2C-master bus responder with a randomised ROM, and a
// transaction-list reference model of what each run should put on the bus.
module tb_i2c_cfg_seq;

    localparam int         DEPTH  = 4;
    localparam int         IW     = 2;
    localparam int         GAPN   = 3;
    localparam int         PMAX   = 20;
    localparam int         MRETRY = 2;
    localparam logic [7:0] CDIV   = 8'd50;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [IW-1:0] err_idx, tbl_addr;
    logic [1:0]    err_code;
    logic [23:0]   tbl_data;
    logic          lb_wr_en, lb_rd_en, lb_wr_valid, lb_rd_valid;
    logic [7:0]    lb_addr;
    logic [31:0]   lb_wr_data, lb_rd_data;
    logic [50:0]   all_outs;

    assign all_outs = {busy, done, err, err_idx, err_code, tbl_addr, lb_wr_en, lb_rd_en, lb_addr, lb_wr_data};

    always #5 clk = ~clk;

    i2c_cfg_seq #(
        .LB_DATA_W(32), .LB_ADDR_W(8), .TBL_DEPTH(DEPTH), .TBL_IDX_W(IW),
        .CLK_DIV_VAL(CDIV), .POLL_GAP(GAPN), .POLL_MAX(16'(PMAX)), .MAX_RETRY(MRETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .err_idx(err_idx), .err_code(err_code), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
        .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data)
    );

    int total = 0;
    int bad = 0;

    logic [23:0] rom [DEPTH];
    always_ff @(posedge clk) tbl_data <= rom[tbl_addr];

    // Responder configuration (written by the test sequence only).
    int delay_min = 0;
    int delay_max = 0;
    int busy_n = 0;
    bit stall = 1'b0;
    bit nack_seq[$];
    int cfg_base = 0;

    // Responder state and logs (written by the responder only).
    acc_t log_q[$];
    int   cfg_count = 0;
    int   extra_strobes = 0;
    int   hold_errs = 0;
    int   done_total = 0;

    always @(negedge clk) if (done === 1'b1) done_total++;

    initial begin
        bit          pend, p_wr, cur_nack;
        logic [7:0]  p_addr;
        logic [31:0] p_data;
        int          p_delay, busy_left, ni;
        pend = 0; p_wr = 0; cur_nack = 0; p_addr = '0; p_data = '0; p_delay = 0; busy_left = 0;
        lb_wr_valid = 1'b0; lb_rd_valid = 1'b0; lb_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            lb_wr_valid = 1'b0;
            lb_rd_valid = 1'b0;
            if (rst_n !== 1'b1) begin
                pend = 0;
                continue;
            end
            if (lb_wr_en === 1'b1 || lb_rd_en === 1'b1) begin
                if (pend) extra_strobes++;
                pend = 1; p_wr = lb_wr_en; p_addr = lb_addr; p_data = lb_wr_data;
                p_delay = $urandom_range(delay_min, delay_max);
            end else if (pend && (lb_addr !== p_addr || (p_wr && lb_wr_data !== p_data))) begin
                hold_errs++;
            end
            if (pend) begin
                if (p_delay > 0) begin
                    p_delay--;
                end else begin
                    pend = 0;
                    if (p_wr) begin
                        lb_wr_valid = 1'b1;
                        log_q.push_back({1'b1, p_addr, p_data});
                        if (p_addr == 8'h02) begin
                            ni = cfg_count - cfg_base;
                            busy_left = busy_n;
                            cur_nack = (ni < nack_seq.size()) ? nack_seq[ni] : 1'b0;
                            cfg_count++;
                        end
                    end else begin
                        lb_rd_valid = 1'b1;
                        log_q.push_back({1'b0, p_addr, 32'h0});
                        lb_rd_data = {30'h0, cur_nack, (stall || busy_left > 0)};
                        if (busy_left > 0) busy_left--;
                    end
                end
            end
        end
    end

    // Reference model: the bus transaction list a run must produce, entry by entry.
    acc_t       exp_q[$];
    bit         exp_err;
    logic [1:0] exp_code;
    int         exp_idx;
    int         exp_done;

    task automatic build_expected();
        int attempt;
        bit fin;
        attempt = 0; fin = 0;
        exp_q.delete(); exp_err = 0; exp_code = 2'b00; exp_idx = 0; exp_done = 0;
        exp_q.push_back({1'b1, 8'h01, 32'(CDIV)});
        for (int e = 0; e < DEPTH && !fin; e++) begin
            int polls;
            polls = 0;
            for (int r = 0; r <= MRETRY && !fin; r++) begin
                bit nk;
                exp_q.push_back({1'b1, 8'h00, 24'h0, rom[e][23:17], 1'b0});
                exp_q.push_back({1'b1, 8'h10, 24'h0, rom[e][15:8]});
                exp_q.push_back({1'b1, 8'h11, 24'h0, rom[e][7:0]});
                exp_q.push_back({1'b1, 8'h02, 32'h0000_0207});
                nk = (attempt < nack_seq.size()) ? nack_seq[attempt] : 1'b0;
                attempt++;
                for (int k = 0; ; k++) begin
                    exp_q.push_back({1'b0, 8'h03, 32'h0});
                    polls++;
                    if (!(stall || k < busy_n)) break;
                    if (polls == PMAX) begin
                        exp_err = 1; exp_code = 2'b10; exp_idx = e; fin = 1;
                        break;
                    end
                end
                if (fin) break;
                if (!nk) break;
                if (r == MRETRY) begin
                    exp_err = 1; exp_code = 2'b01; exp_idx = e; fin = 1;
                end
            end
        end
        if (!fin) exp_done = 1;
    endtask

    int log_base = 0;
    int strobe_base = 0;
    int hold_base = 0;
    int done_base = 0;
    logic err_after_start;

    task automatic run_seq(input int extra_start_at, output bit timed_out);
        log_base = log_q.size(); cfg_base = cfg_count;
        strobe_base = extra_strobes; hold_base = hold_errs; done_base = done_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; err_after_start = err;
        timed_out = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (busy !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            start = (c == extra_start_at);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic int trace_diff();
        int n;
        n = log_q.size() - log_base;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (log_q[log_base + i] !== exp_q[i]) return i;
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    function automatic int count_acc(input logic wr, input logic [7:0] a);
        int c;
        c = 0;
        for (int i = log_base; i < log_q.size(); i++)
            if (log_q[i].wr == wr && log_q[i].addr == a) c++;
        return c;
    endfunction

    task automatic randomize_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 24'($urandom());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%h want=0", all_outs);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== '0) begin
            bad++; $display("[TB] FAIL idle_after_reset got=%h want=0", all_outs);
        end
    endtask

    task automatic test_basic();
        bit to;
        int d;
        randomize_rom();
        rom[0] = {7'h1A, 1'b0, 8'h0E, 8'h42};
        rom[1] = {7'h1A, 1'b0, 8'h10, 8'h05};
        nack_seq.delete(); stall = 0; busy_n = $urandom_range(0, 3); delay_min = 0; delay_max = 2;
        build_expected();
        run_seq(-1, to);
        total++; if (to) begin bad++; $display("[TB] FAIL basic_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL basic_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (log_q.size() < log_base + 2 || log_q[log_base + 1] !== {1'b1, 8'h00, 32'h34}) begin
            bad++; $display("[TB] FAIL basic_devaddr got=%h want=%h", log_q[log_base + 1], {1'b1, 8'h00, 32'h34});
        end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got=%b want=0", err); end
        total++; if (done_total - done_base != 1) begin bad++; $display("[TB] FAIL basic_done got=%0d want=1", done_total - done_base); end
        total++; if (extra_strobes != strobe_base || hold_errs != hold_base) begin
            bad++; $display("[TB] FAIL basic_handshake got=%0d/%0d want=0/0", extra_strobes - strobe_base, hold_errs - hold_base);
        end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 3; it++) begin
            bit to;
            int d;
            randomize_rom();
            nack_seq.delete();
            for (int j = 0; j < 6; j++) nack_seq.push_back(1'($urandom_range(0, 1)));
            stall = 0; busy_n = $urandom_range(0, 3); delay_min = 0; delay_max = 3;
            build_expected();
            run_seq(-1, to);
            total++; if (to) begin bad++; $display("[TB] FAIL rand%0d_timeout got=busy want=idle", it); end
            d = trace_diff();
            total++; if (d != -1) begin bad++; $display("[TB] FAIL rand%0d_trace at=%0d got=%h want=%h", it, d, log_q[log_base + d], exp_q[d]); end
            total++; if ({err, err_code, err_idx} !== {exp_err, exp_code, IW'(exp_idx)}) begin
                bad++; $display("[TB] FAIL rand%0d_errs got=%b/%b/%0d want=%b/%b/%0d", it, err, err_code, err_idx, exp_err, exp_code, exp_idx);
            end
            total++; if (done_total - done_base != exp_done) begin bad++; $display("[TB] FAIL rand%0d_done got=%0d want=%0d", it, done_total - done_base, exp_done); end
            total++; if (extra_strobes != strobe_base || hold_errs != hold_base) begin
                bad++; $display("[TB] FAIL rand%0d_handshake got=%0d/%0d want=0/0", it, extra_strobes - strobe_base, hold_errs - hold_base);
            end
        end
    endtask

    task automatic test_nack_fail();
        bit to;
        int d;
        randomize_rom();
        nack_seq.delete(); nack_seq.push_back(1); nack_seq.push_back(1); nack_seq.push_back(1);
        stall = 0; busy_n = $urandom_range(0, 2); delay_min = 0; delay_max = 2;
        build_expected();
        run_seq(-1, to);
        total++; if (to) begin bad++; $display("[TB] FAIL nack_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL nack_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (count_acc(1'b1, 8'h02) != 3) begin bad++; $display("[TB] FAIL nack_cfg_writes got=%0d want=3", count_acc(1'b1, 8'h02)); end
        total++; if ({err, err_code, err_idx} !== {1'b1, 2'b01, IW'(0)}) begin
            bad++; $display("[TB] FAIL nack_errs got=%b/%b/%0d want=1/01/0", err, err_code, err_idx);
        end
        total++; if (done_total != done_base) begin bad++; $display("[TB] FAIL nack_done got=%0d want=0", done_total - done_base); end
    endtask

    task automatic test_timeout();
        bit to;
        int d;
        randomize_rom();
        nack_seq.delete(); stall = 1; busy_n = 0; delay_min = 0; delay_max = 1;
        build_expected();
        run_seq(-1, to);
        stall = 0;
        total++; if (to) begin bad++; $display("[TB] FAIL tmo_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL tmo_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (count_acc(1'b0, 8'h03) != PMAX) begin bad++; $display("[TB] FAIL tmo_status_reads got=%0d want=%0d", count_acc(1'b0, 8'h03), PMAX); end
        total++; if ({err, err_code, err_idx} !== {1'b1, 2'b10, IW'(0)}) begin
            bad++; $display("[TB] FAIL tmo_errs got=%b/%b/%0d want=1/10/0", err, err_code, err_idx);
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        int d;
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL swb_err_sticky got=%b want=1", err); end
        randomize_rom();
        nack_seq.delete(); stall = 0; busy_n = $urandom_range(0, 3); delay_min = 0; delay_max = 2;
        build_expected();
        run_seq(30, to);
        total++; if (err_after_start !== 1'b0) begin bad++; $display("[TB] FAIL swb_err_cleared got=%b want=0", err_after_start); end
        total++; if (to) begin bad++; $display("[TB] FAIL swb_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL swb_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (done_total - done_base != 1 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL swb_result got=%0d/%b want=1/0", done_total - done_base, err);
        end
    endtask

    task automatic test_reset_mid_run();
        bit to, found;
        int d;
        randomize_rom();
        nack_seq.delete(); stall = 0; busy_n = $urandom_range(0, 2); delay_min = 1; delay_max = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (lb_wr_en === 1'b1 && lb_addr === 8'h10) begin
                found = 1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL rst_mid_reach got=none want=wr_d0_strobe"); end
        rst_n = 1'b0;
        #1;
        total++; if (all_outs !== '0) begin bad++; $display("[TB] FAIL rst_mid_outputs got=%h want=0", all_outs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        build_expected();
        run_seq(-1, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rst_rerun_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL rst_rerun_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (done_total - done_base != 1 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_rerun_result got=%0d/%b want=1/0", done_total - done_base, err);
        end
    endtask

    task automatic test_slow_ack();
        bit to;
        int d;
        randomize_rom();
        nack_seq.delete(); stall = 0; busy_n = 1; delay_min = 5; delay_max = 5;
        build_expected();
        run_seq(-1, to);
        total++; if (to) begin bad++; $display("[TB] FAIL slow_timeout got=busy want=idle"); end
        d = trace_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL slow_trace at=%0d got=%h want=%h", d, log_q[log_base + d], exp_q[d]); end
        total++; if (extra_strobes != strobe_base) begin bad++; $display("[TB] FAIL slow_extra_strobe got=%0d want=0", extra_strobes - strobe_base); end
        total++; if (hold_errs != hold_base) begin bad++; $display("[TB] FAIL slow_hold got=%0d want=0", hold_errs - hold_base); end
        total++; if (done_total - done_base != 1) begin bad++; $display("[TB] FAIL slow_done got=%0d want=1", done_total - done_base); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        test_reset();
        test_basic();
        test_random_runs();
        test_nack_fail();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_run();
        test_slow_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LB_DATA_W, 32, local-bus data width.
- LB_ADDR_W, 8, local-bus address width.
- TBL_DEPTH, 16, number of configuration entries.
- TBL_IDX_W, 4, table index width; equals $clog2(TBL_DEPTH).
- CLK_DIV_VAL, 8'd50, value written to the I2C clock-divider register.
- POLL_GAP, 8, idle cycles between status polls.
- POLL_MAX, 16'hFFFF, poll count before timeout.
- MAX_RETRY, 2, retries per entry on NACK.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, one-cycle pulse; runs the whole table.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle pulse on successful completion.
- err, out, 1, sticky; cleared by the next start.
- err_idx, out, TBL_IDX_W, index of the failing entry.
- err_code, out, 2, 01 = NACK, 10 = timeout.
- tbl_addr, out, TBL_IDX_W, table ROM address.
- tbl_data, in, 24, ROM data; 1-cycle read latency; fields [23:17] device address, [15:8] byte0, [7:0] byte1.
- lb_wr_en, out, 1, local-bus write strobe toward the I2C master.
- lb_rd_en, out, 1, local-bus read strobe toward the I2C master.
- lb_addr, out, LB_ADDR_W, local-bus address.
- lb_wr_data, out, LB_DATA_W, local-bus write data.
- lb_wr_valid, in, 1, write acknowledge from the I2C master.
- lb_rd_valid, in, 1, read-data valid from the I2C master.
- lb_rd_data, in, LB_DATA_W, read data from the I2C master.

Function
REQ-003 Master register map: ADDR 0x00, CLK_DIV 0x01, CONFIG 0x02, STATUS 0x03 (bit0 busy, bit1 nack), DATA_CACHE base 0x10.
REQ-004 Every local-bus access SHALL be one lb_wr_en/lb_rd_en pulse, then a wait for lb_wr_valid/lb_rd_valid; at most one access is outstanding.
REQ-005 FSM states SHALL be IDLE, CLKDIV, FETCH, WR_ADDR, WR_D0, WR_D1, WR_CFG, GAP, POLL, CHECK, NEXT, FAIL.
REQ-006 IDLE + start: clear err, set idx=0 and retry=0, then go to CLKDIV. start SHALL be ignored when busy=1.
REQ-007 CLKDIV: write CLK_DIV_VAL to 0x01, then go to FETCH; this write occurs once per run.
REQ-008 FETCH: drive tbl_addr=idx, wait 1 cycle, then latch tbl_data into an entry register.
REQ-009 WR_ADDR writes {dev,1'b0} to 0x00; WR_D0 writes byte0 to 0x10; WR_D1 writes byte1 to 0x11.
REQ-010 WR_CFG: write 0x0000_0207 to 0x02 (num_bytes=2, init, stop_en, start_en, write direction).
REQ-011 GAP: count POLL_GAP cycles after each config write and after each busy poll; the first poll SHALL NOT precede the gap.
REQ-012 POLL: read 0x03 and increment the poll counter (16 bit). busy=1 returns to GAP. If the counter reaches POLL_MAX, go to FAIL with code 10.
REQ-013 CHECK: nack=0 goes to NEXT. nack=1 with retry<MAX_RETRY increments retry and re-enters WR_ADDR. Otherwise go to FAIL with code 01.
REQ-014 NEXT: if idx==TBL_DEPTH-1, pulse done and go to IDLE; else idx+1, retry=0, poll counter=0, go to FETCH. The index SHALL NOT wrap.
REQ-015 FAIL: set err, err_idx=idx, err_code, then go to IDLE without writing further entries.
REQ-016 busy=1 in every state except IDLE; done is asserted only in the cycle leaving NEXT.
REQ-017 lb_addr and lb_wr_data SHALL be registered and held stable from the strobe until its valid.

Reset
REQ-018 Reset values: all outputs 0, state IDLE, all counters 0.
REQ-019 Reset mid-run SHALL abort immediately with no pending strobe; the next run restarts at entry 0.

Structure
REQ-020 Shared package i2c_pkg: master register-address constants, STATUS bit positions, CONFIG field positions, err_code enum.
REQ-021 Sub-module lb_xact: single-access local-bus handshake engine (req/wr/addr/data in, ack/rdata out).

Verification
REQ-022 Two entries {0x1A,0x0E,0x42}, {0x1A,0x10,0x05}, slave ACKs -> writes 0x01, 0x00=0x34, 0x10=0x0E, 0x11=0x42, 0x02=0x207, polls, then the second entry; one done pulse, err=0.
REQ-023 Entry 0 NACKed three times, MAX_RETRY=2 -> 3 CONFIG writes, err=1, err_code=01, err_idx=0, no entry-1 writes.
REQ-024 Slave stalls busy=1 and POLL_MAX=20 -> exactly 20 STATUS reads, err_code=10.
REQ-025 start pulsed while busy -> ignored, sequence unaffected; start after err -> err cleared and run from idx 0.
REQ-026 rst_n asserted during WR_D0 -> all outputs 0 next cycle; a new start yields a clean full run.
REQ-027 lb_wr_valid delayed by 5 cycles -> no second strobe issued; address/data held throughout.
